// File: rtl/data_memory_responder.sv
// data_memory_responder: byte-serial load/store unit with a byte-wide storage
// array and one memory-mapped 8-bit output register at IO_ADDRESS.
// Optional build macro: DATA_MEMORY_BOUNDS_CHECK_EN rejects non-IO addresses
// at or above DEPTH_BYTES instead of letting them alias.
module data_memory_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] IO_ADDRESS  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_read,
  input  logic        request_write,
  input  logic [2:0]  subfunction_3,
  input  logic [31:0] input_register1_value,
  input  logic [31:0] input_register2_value,
  input  logic [31:0] immediate,
  output logic        clk_stall,
  output logic        decoding_error,
  output logic [31:0] result_to_write_rd,
  output logic [7:0]  memory_mapped_io
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] asm_q;
  logic [2:0]  sub_q;
  logic        write_q;
  logic [1:0]  cnt_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [31:0]      eff_addr;
  logic             sub_ok;
  logic             align_ok;
  logic             bounds_ok;
  logic             req_valid;
  logic             req_reject;
  logic [31:0]      byte_addr;
  logic             io_hit;
  logic [IDX_W-1:0] idx;
  logic [7:0]       wr_byte;
  logic [7:0]       rd_byte;
  logic [1:0]       last_cnt;
  logic             last;
  logic [31:0]      asm_next;
  logic [31:0]      ext_result;

  assign eff_addr = input_register1_value + immediate;

  // Request decode: encoding, alignment and (optionally) range checks
  always_comb begin
    sub_ok    = 1'b0;
    align_ok  = 1'b0;
    bounds_ok = 1'b1;
    case (subfunction_3)
      3'd0, 3'd1, 3'd2: sub_ok = 1'b1;
      3'd4, 3'd5:       sub_ok = ~request_write;
      default:          sub_ok = 1'b0;
    endcase
    case (subfunction_3[1:0])
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~eff_addr[0];
      2'd2:    align_ok = (eff_addr[1:0] == 2'd0);
      default: align_ok = 1'b0;
    endcase
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    bounds_ok = (eff_addr == IO_ADDRESS) || (eff_addr < 32'(DEPTH_BYTES));
`endif
  end

  assign req_valid  = (state == IDLE) && (request_read ^ request_write)
                      && sub_ok && align_ok && bounds_ok;
  assign req_reject = (state == IDLE) && (request_read | request_write) && ~req_valid;
  assign clk_stall  = req_valid || (state == BUSY);

  // Per-byte datapath for the current BUSY cycle
  assign byte_addr = addr_q + 32'(cnt_q);
  assign io_hit    = (byte_addr == IO_ADDRESS);
  assign idx       = byte_addr[IDX_W-1:0];
  assign wr_byte   = data_q[{cnt_q, 3'b000} +: 8];
  assign rd_byte   = io_hit ? memory_mapped_io : mem[idx];

  // Last byte index for the latched access size
  always_comb begin
    case (sub_q[1:0])
      2'd0:    last_cnt = 2'd0;
      2'd1:    last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end
  assign last = (cnt_q == last_cnt);

  // Assemble the load lane and apply sign/zero extension
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = rd_byte;
    case (sub_q)
      3'd0:    ext_result = {{24{asm_next[7]}}, asm_next[7:0]};
      3'd1:    ext_result = {{16{asm_next[15]}}, asm_next[15:0]};
      3'd4:    ext_result = {24'd0, asm_next[7:0]};
      3'd5:    ext_result = {16'd0, asm_next[15:0]};
      default: ext_result = asm_next;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      decoding_error     <= 1'b0;
      result_to_write_rd <= 32'd0;
      memory_mapped_io   <= 8'd0;
      addr_q             <= 32'd0;
      data_q             <= 32'd0;
      asm_q              <= 32'd0;
      sub_q              <= 3'd0;
      write_q            <= 1'b0;
      cnt_q              <= 2'd0;
    end else begin
      decoding_error <= req_reject;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= eff_addr;
            data_q  <= input_register2_value;
            sub_q   <= subfunction_3;
            write_q <= request_write;
            cnt_q   <= 2'd0;
            asm_q   <= 32'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (write_q && io_hit) memory_mapped_io <= wr_byte;
          if (!write_q) asm_q <= asm_next;
          cnt_q <= cnt_q + 2'd1;
          if (last) begin
            state <= DONE;
            if (!write_q) result_to_write_rd <= ext_result;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage write port; contents are never reset
  always_ff @(posedge clk) begin
    if (!reset && state == BUSY && write_q && !io_hit) mem[idx] <= wr_byte;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with hand-computed expectations.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        request_read;
  logic        request_write;
  logic [2:0]  subfunction_3;
  logic [31:0] input_register1_value;
  logic [31:0] input_register2_value;
  logic [31:0] immediate;
  logic        clk_stall;
  logic        decoding_error;
  logic [31:0] result_to_write_rd;
  logic [7:0]  memory_mapped_io;

  int total = 0;
  int bad   = 0;

  data_memory_responder #(.DEPTH_BYTES(1024), .IO_ADDRESS(32'hFFFF_FF00)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .request_read          (request_read),
    .request_write         (request_write),
    .subfunction_3         (subfunction_3),
    .input_register1_value (input_register1_value),
    .input_register2_value (input_register2_value),
    .immediate             (immediate),
    .clk_stall             (clk_stall),
    .decoding_error        (decoding_error),
    .result_to_write_rd    (result_to_write_rd),
    .memory_mapped_io      (memory_mapped_io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: drive for one cycle, count stall cycles, check error and result.
  task automatic access(input logic rd, input logic wr, input logic [2:0] sub,
                        input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [31:0] rs2, input int exp_stall,
                        input logic exp_err, input logic chk_res,
                        input logic [31:0] exp_res, input string tag);
    int stalls;
    @(negedge clk);
    request_read          = rd;
    request_write         = wr;
    subfunction_3         = sub;
    input_register1_value = rs1;
    immediate             = imm;
    input_register2_value = rs2;
    #1;
    stalls = clk_stall ? 1 : 0;
    @(posedge clk);
    #1;
    request_read  = 1'b0;
    request_write = 1'b0;
    #1;
    chk({tag, ".err"}, 32'(decoding_error), 32'(exp_err));
    for (int i = 0; i < 8 && clk_stall; i++) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    chk({tag, ".stall"}, 32'(stalls), 32'(exp_stall));
    if (chk_res) chk({tag, ".rd"}, result_to_write_rd, exp_res);
    @(posedge clk);
    #1;
    chk({tag, ".err_clear"}, 32'(decoding_error), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    request_read = 1'b0;
    request_write = 1'b0;
    subfunction_3 = 3'd0;
    input_register1_value = 32'd0;
    input_register2_value = 32'd0;
    immediate = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall", 32'(clk_stall), 32'd0);
    chk("rst.err", 32'(decoding_error), 32'd0);
    chk("rst.rd", result_to_write_rd, 32'd0);
    chk("rst.mmio", 32'(memory_mapped_io), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word store/load and sub-word loads of the same word
    access(0, 1, 3'd2, 32'h10, 32'h4, 32'hDEADBEEF, 5, 0, 0, 0, "sw14");
    access(1, 0, 3'd2, 32'h10, 32'h4, 0, 5, 0, 1, 32'hDEADBEEF, "lw14");
    access(1, 0, 3'd4, 32'h17, 32'h0, 0, 2, 0, 1, 32'h000000DE, "lbu17");
    access(1, 0, 3'd0, 32'h14, 32'h0, 0, 2, 0, 1, 32'hFFFFFFEF, "lb14");
    access(1, 0, 3'd1, 32'h16, 32'h0, 0, 3, 0, 1, 32'hFFFFDEAD, "lh16");
    access(1, 0, 3'd5, 32'h16, 32'h0, 0, 3, 0, 1, 32'h0000DEAD, "lhu16");
    access(1, 0, 3'd1, 32'h18, 32'hFFFFFFFC, 0, 3, 0, 1, 32'hFFFFBEEF, "lh14neg");

    // IO register store/load
    access(0, 1, 3'd0, 32'hFFFFFF10, 32'hFFFFFFF0, 32'h0000005A, 2, 0, 0, 0, "sb_io");
    chk("sb_io.mmio", 32'(memory_mapped_io), 32'h5A);
    access(1, 0, 3'd4, 32'hFFFFFF00, 32'h0, 0, 2, 0, 1, 32'h0000005A, "lbu_io");

    // Known word at 0 for later storage-unchanged and alias checks
    access(0, 1, 3'd2, 32'h0, 32'h0, 32'h01020304, 5, 0, 0, 0, "sw0");

    // Rejected requests: error pulse, no stall, no access
    access(1, 0, 3'd2, 32'h102, 32'h0, 0, 0, 1, 0, 0, "lw_misalign");
    access(0, 1, 3'd1, 32'h1, 32'h0, 32'hFFFFFFFF, 0, 1, 0, 0, "sh_misalign");
    access(1, 0, 3'd3, 32'h14, 32'h0, 0, 0, 1, 0, 0, "lh_badsub");
    access(1, 1, 3'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1, 0, 0, "rdwr");
    access(0, 1, 3'd4, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1, 0, 0, "sbu_badsub");
    access(1, 0, 3'd2, 32'h0, 32'h0, 0, 5, 0, 1, 32'h01020304, "lw0_kept");
    access(1, 0, 3'd2, 32'h14, 32'h0, 0, 5, 0, 1, 32'hDEADBEEF, "lw14_kept");
    chk("mmio_kept", 32'(memory_mapped_io), 32'h5A);

    // Address wrap past 0xFFFF_FFFF
    access(1, 0, 3'd0, 32'hFFFFFFFF, 32'h1, 0, 2, 0, 1, 32'h00000004, "lb_wrap");

    // Reset on the second BUSY cycle of a word store
    access(0, 1, 3'd2, 32'h20, 32'h0, 32'hAABBCCDD, 5, 0, 0, 0, "sw20_old");
    @(negedge clk);
    request_write         = 1'b1;
    subfunction_3         = 3'd2;
    input_register1_value = 32'h20;
    immediate             = 32'h0;
    input_register2_value = 32'h11223344;
    @(posedge clk);
    #1;
    request_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid.stall", 32'(clk_stall), 32'd0);
    chk("rstmid.rd", result_to_write_rd, 32'd0);
    reset = 1'b0;
    access(1, 0, 3'd4, 32'h20, 32'h0, 0, 2, 0, 1, 32'h00000044, "rstmid.b20");
    access(1, 0, 3'd4, 32'h22, 32'h0, 0, 2, 0, 1, 32'h000000BB, "rstmid.b22");
    access(1, 0, 3'd4, 32'h23, 32'h0, 0, 2, 0, 1, 32'h000000AA, "rstmid.b23");

    // Out-of-range address: rejected or aliases to address 0
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    access(1, 0, 3'd2, 32'd1024, 32'h0, 0, 0, 1, 0, 0, "lw_depth");
`else
    access(1, 0, 3'd2, 32'd1024, 32'h0, 0, 5, 0, 1, 32'h01020304, "lw_depth");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Byte-serial data memory that services the core's load/store requests and owns the 8-bit memory-mapped output port. It computes the effective address from rs1 plus the immediate. It holds `clk_stall` high while it moves one byte per cycle between the core and a byte-wide storage array, then presents load data sign- or zero-extended per `subfunction_3`.

## Interface
Parameters:
- `DEPTH_BYTES`, 1024: storage size in bytes; must be a power of two.
- `IO_ADDRESS`, 32'hFFFF_FF00: byte address of the memory-mapped output register.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, ungated (not `clk_with_stalls`).
- `reset`  in  1  synchronous active-high reset.
- `request_read`  in  1  load requested this cycle.
- `request_write`  in  1  store requested this cycle.
- `subfunction_3`  in  3  load: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store: 0 SB, 1 SH, 2 SW.
- `input_register1_value`  in  32  base address (rs1).
- `input_register2_value`  in  32  store data (rs2).
- `immediate`  in  32  sign-extended offset.
- `clk_stall`  out  1  core must hold its state while high.
- `decoding_error`  out  1  one-cycle pulse for a rejected request.
- `result_to_write_rd`  out  32  load result, valid in DONE and held until the next load completes.
- `memory_mapped_io`  out  8  last byte stored to `IO_ADDRESS`.

## Operation
- Effective address is `input_register1_value + immediate`, computed modulo 2^32.
- Storage index is address mod `DEPTH_BYTES`. Storage contents are not reset.
- Transfer size N is 1, 2 or 4 bytes, from `subfunction_3[1:0]`.
- Byte order is little-endian: byte k of the access goes to or comes from address+k.
- States are IDLE, BUSY and DONE.

IDLE:
- A request is rejected if any of the following holds:
  - both `request_read` and `request_write` are high;
  - `subfunction_3` is invalid for the operation;
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0.
- A rejected request pulses `decoding_error` for one cycle, causes no access and no stall, and the state stays IDLE.
- A valid request latches the address, store data, `subfunction_3` and direction, clears the byte counter, asserts `clk_stall` and moves to BUSY.

BUSY:
- Transfers one byte per cycle, for N cycles.
- A store writes byte k of the latched rs2.
- A load places the byte into lane k of an assembly register.
- If the byte address equals `IO_ADDRESS`:
  - a store writes `memory_mapped_io` instead of storage;
  - a load reads `memory_mapped_io` instead of storage.
- After byte N-1 the state moves to DONE.

DONE:
- `clk_stall` is low.
- For a load, `result_to_write_rd` is updated with the assembled value, extended:
  - LB: sign-extended from bit 7;
  - LH: sign-extended from bit 15;
  - LBU, LHU: zero-extended.
- Requests seen in DONE belong to the finished access and are ignored.
- Next state is IDLE.

## Timing
- `clk_stall` is combinational: high when (IDLE and a valid request) or BUSY. It is high for exactly N+1 consecutive cycles per valid access.
- Load data is visible in DONE, N+1 cycles after acceptance.
- A store updates storage or the IO register at the edge ending each BUSY cycle.
- Back-to-back requests: earliest next acceptance is the cycle after DONE.
- Address wraps past 0xFFFF_FFFF; the storage index wraps at `DEPTH_BYTES`.
- A multi-byte access at `IO_ADDRESS` touches the IO register only for the byte that matches `IO_ADDRESS`.
- Reset values: state IDLE, `clk_stall`=0, `decoding_error`=0, `result_to_write_rd`=0, `memory_mapped_io`=0.
- Reset mid-access returns to IDLE the next cycle. Bytes already written stay written, and no result is presented.

## Configuration
- `DATA_MEMORY_BOUNDS_CHECK_EN` defined:
  - any non-IO address with addr >= `DEPTH_BYTES` is rejected in IDLE with a `decoding_error` pulse and no stall.
- `DATA_MEMORY_BOUNDS_CHECK_EN` undefined:
  - such addresses alias modulo `DEPTH_BYTES`;
  - `decoding_error` is raised only for the alignment and encoding errors listed under Operation.

## Test plan
- SW rs1=0x10, imm=4, rs2=0xDEADBEEF, then LW of the same address -> store stalls 5 cycles; load stalls 5 cycles and returns 0xDEADBEEF; LBU at 0x17 -> 0x000000DE.
- LB at 0x14 after the store above -> 0xFFFFFFEF; LH at 0x16 -> 0xFFFFDEAD; LHU at 0x16 -> 0x0000DEAD.
- SB rs2=0x5A to `IO_ADDRESS` (rs1=0xFFFF_FF10, imm=-16) -> `memory_mapped_io`=0x5A after 2 stall cycles; LBU of `IO_ADDRESS` -> 0x0000005A.
- LW at 0x102, SH at 0x1, LH with `subfunction_3`=3, and read+write together -> each gives a one-cycle `decoding_error`, `clk_stall` stays 0, and storage is unchanged.
- Assert `reset` on the second BUSY cycle of SW 0x11223344 to 0x20 -> next cycle IDLE and stall 0; byte 0x20=0x44, and 0x22–0x23 keep their old values.
- With `DATA_MEMORY_BOUNDS_CHECK_EN`, LW at `DEPTH_BYTES` -> `decoding_error`. Without it -> returns the word at address 0.
